// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, the canonical NOP and the
// fetch-to-decode issue FSM state encoding.
package core_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // addi x0,x0,0 -- shown to the decoder whenever no real head exists
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } issue_state_t;

endpackage

// File: rtl/dec_issue_ctrl_if.sv
// Signal bundle between the issue controller and its neighbours
// (IFU, decoder dec_swc, EX stage, branch unit).
//
// Handshakes: a transfer happens on the rising hclk edge where valid and
// ready are both high. if_valid/if_ready moves one IFU word into the
// buffer; dec_valid/ex_ready (qualified by the load-use check and flush)
// moves the head to EX, reported as issue_valid. Ready may depend
// combinationally on valid-side state, never the other way round.
interface dec_issue_ctrl_if;
    import core_pkg::*;

    logic                if_valid;
    logic [XLEN-1:0]     if_inst;
    logic [XLEN-1:0]     if_pc;
    logic                if_ready;

    logic [XLEN-1:0]     dec_inst;
    logic [XLEN-1:0]     dec_pc;
    logic                dec_valid;
    logic                ifu_dec_stall;
    logic [3:0]          cycle_cnt;
    logic [REG_AW-1:0]   dec_rs1;
    logic [REG_AW-1:0]   dec_rs2;
    logic                dec_uses_rs1;
    logic                dec_uses_rs2;

    logic                ex_load_en;
    logic [REG_AW-1:0]   ex_rd;
    logic                ex_ready;
    logic                flush;
    logic                issue_valid;

    // Environment side: IFU, decoder, EX and branch unit
    modport master (
        output if_valid, if_inst, if_pc,
        output dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
        output ex_load_en, ex_rd, ex_ready, flush,
        input  if_ready, dec_inst, dec_pc, dec_valid,
        input  ifu_dec_stall, cycle_cnt, issue_valid
    );

    // Controller side
    modport slave (
        input  if_valid, if_inst, if_pc,
        input  dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
        input  ex_load_en, ex_rd, ex_ready, flush,
        output if_ready, dec_inst, dec_pc, dec_valid,
        output ifu_dec_stall, cycle_cnt, issue_valid
    );

endinterface

// File: rtl/dec_issue_fifo.sv
// Small instruction buffer with extra-MSB pointers so full and empty are
// distinguishable without a separate count register.
module dec_issue_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // clear wins over any simultaneous push or pop
    assign do_push = push_i && !full_o && !clear_i;
    assign do_pop  = pop_i && !empty_o && !clear_i;

    // Pointer next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge clk_i) begin
        if (do_push && !rst_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/dec_issue_ctrl.sv
// Fetch-to-decode issue controller: buffers IFU words, presents the head
// to the decoder, holds it on load-use hazards or EX back-pressure and
// recovers from branch redirects through a one-cycle FLUSH state.
module dec_issue_ctrl
    import core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             hclk,
    input  logic             hrst,
    dec_issue_ctrl_if.slave  bus,
    output issue_state_t     dbg_state_o
);

    localparam int AW = $clog2(DEPTH);

    issue_state_t      state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;

    logic [2*XLEN-1:0] head;
    logic              fifo_full, fifo_empty;
    logic [AW:0]       fifo_count;

    logic              dec_valid, lu, issue, stall, push, empties;

    dec_issue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*XLEN)
    ) u_fifo (
        .clk_i   (hclk),
        .rst_i   (hrst),
        .clear_i (bus.flush),
        .push_i  (push),
        .wdata_i ({bus.if_inst, bus.if_pc}),
        .pop_i   (issue),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign dec_valid = !fifo_empty && (state_q != FLUSH);

    assign lu = dec_valid && bus.ex_load_en && (bus.ex_rd != '0) &&
                ((bus.dec_uses_rs1 && (bus.dec_rs1 == bus.ex_rd)) ||
                 (bus.dec_uses_rs2 && (bus.dec_rs2 == bus.ex_rd)));

    assign issue = dec_valid && bus.ex_ready && !lu && !bus.flush;
    assign stall = dec_valid && !issue;

    assign bus.if_ready = !fifo_full && (state_q != FLUSH) && !bus.flush;
    assign push         = bus.if_valid && bus.if_ready;

    // the last buffered word leaves and nothing replaces it
    assign empties = issue && !push && (fifo_count == (AW+1)'(1));

    assign bus.dec_valid     = dec_valid;
    assign bus.dec_inst      = dec_valid ? head[2*XLEN-1:XLEN] : NOP;
    assign bus.dec_pc        = dec_valid ? head[XLEN-1:0] : '0;
    assign bus.issue_valid   = issue;
    assign bus.ifu_dec_stall = stall;
    assign bus.cycle_cnt     = cnt_q;
    assign dbg_state_o       = state_q;

    // FSM next-state; a redirect overrides every other event
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (push) state_d = RUN;
            RUN:     if (stall) state_d = HOLD;
                     else if (empties) state_d = IDLE;
            HOLD:    if (issue) state_d = empties ? IDLE : RUN;
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.flush) state_d = FLUSH;
    end

    // Hold counter: counts cycles the current head waits, saturating at 15
    always_comb begin
        cnt_d = '0;
        if (stall && !bus.flush) cnt_d = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;
    end

    // State and counter registers
    always_ff @(posedge hclk) begin
        if (hrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dec_issue_ctrl.sv
// Bench for dec_issue_ctrl: directed scenarios plus a randomized run, all
// checked against a queue-based model of the issue controller.
module tb_dec_issue_ctrl;
    import core_pkg::*;

    localparam int DEPTH = 2;

    logic         hclk;
    logic         hrst;
    issue_state_t dbg_state;
    int           n_checks;
    int           n_fail;

    dec_issue_ctrl_if bus ();

    dec_issue_ctrl #(.DEPTH(DEPTH)) dut (
        .hclk        (hclk),
        .hrst        (hrst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // ---------------- reference model ----------------
    logic [63:0] exp_q[$];          // buffered {inst, pc}, head at index 0
    bit          m_flush_rec;       // redirect recovery cycle
    int          m_cnt;
    logic        e_dec_valid, e_issue, e_stall, e_if_ready;
    logic [31:0] e_inst, e_pc;
    logic [3:0]  e_cnt;

    function automatic void model_eval();
        logic lu;
        e_dec_valid = (exp_q.size() > 0) && !m_flush_rec;
        e_inst      = e_dec_valid ? exp_q[0][63:32] : 32'h0000_0013;
        e_pc        = e_dec_valid ? exp_q[0][31:0] : 32'h0;
        lu = e_dec_valid && bus.ex_load_en && (bus.ex_rd != 5'd0) &&
             ((bus.dec_uses_rs1 && bus.dec_rs1 == bus.ex_rd) ||
              (bus.dec_uses_rs2 && bus.dec_rs2 == bus.ex_rd));
        e_issue    = e_dec_valid && bus.ex_ready && !lu && !bus.flush;
        e_stall    = e_dec_valid && !e_issue;
        e_if_ready = (exp_q.size() < DEPTH) && !m_flush_rec && !bus.flush;
        e_cnt      = 4'(m_cnt);
    endfunction

    // advance the model across one rising edge, then step to edge+1
    task automatic tick();
        model_eval();
        if (hrst) begin
            exp_q.delete(); m_flush_rec = 0; m_cnt = 0;
        end else if (bus.flush) begin
            exp_q.delete(); m_flush_rec = 1; m_cnt = 0;
        end else begin
            m_flush_rec = 0;
            m_cnt = e_stall ? ((m_cnt < 15) ? m_cnt + 1 : 15) : 0;
            if (e_issue) void'(exp_q.pop_front());
            if (bus.if_valid && e_if_ready) exp_q.push_back({bus.if_inst, bus.if_pc});
        end
        @(posedge hclk);
        #1;
    endtask

    // ---------------- drivers ----------------
    task automatic drive_quiet();
        bus.if_valid = 0; bus.if_inst = 32'h0; bus.if_pc = 32'h0;
        bus.dec_rs1 = 5'd0; bus.dec_rs2 = 5'd0;
        bus.dec_uses_rs1 = 0; bus.dec_uses_rs2 = 0;
        bus.ex_load_en = 0; bus.ex_rd = 5'd0; bus.ex_ready = 0; bus.flush = 0;
    endtask

    task automatic drive_push(input logic [31:0] inst, input logic [31:0] pc);
        bus.if_valid = 1; bus.if_inst = inst; bus.if_pc = pc;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive_quiet();
        hrst = 1;
        drive_push(32'h0010_0093, 32'h40);
        repeat (3) tick();
        hrst = 0;
        bus.if_valid = 0;
        @(negedge hclk);
        n_checks++; if (bus.dec_inst !== 32'h13) begin n_fail++; $display("FAIL reset_dec_inst got=%h exp=%h", bus.dec_inst, 32'h13); end
        n_checks++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dec_valid got=%b exp=0", bus.dec_valid); end
        n_checks++; if (bus.dec_pc !== 32'h0) begin n_fail++; $display("FAIL reset_dec_pc got=%h exp=0", bus.dec_pc); end
        n_checks++; if (bus.if_ready !== 1'b1) begin n_fail++; $display("FAIL reset_if_ready got=%b exp=1", bus.if_ready); end
        n_checks++; if (bus.issue_valid !== 1'b0 || bus.ifu_dec_stall !== 1'b0) begin n_fail++; $display("FAIL reset_issue_stall got=%b%b exp=00", bus.issue_valid, bus.ifu_dec_stall); end
        n_checks++; if (bus.cycle_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cycle_cnt got=%0d exp=0", bus.cycle_cnt); end
        n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
        tick();
    endtask

    task automatic test_streaming();
        drive_quiet();
        bus.ex_ready = 1;
        drive_push(32'h0050_0093, 32'h0);
        @(negedge hclk);
        n_checks++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL stream_c0_valid got=%b exp=0", bus.dec_valid); end
        tick();
        drive_push(32'h00A0_0113, 32'h4);
        @(negedge hclk);
        n_checks++; if (bus.issue_valid !== 1'b1 || bus.dec_pc !== 32'h0) begin n_fail++; $display("FAIL stream_first got=%b/%h exp=1/0", bus.issue_valid, bus.dec_pc); end
        n_checks++; if (bus.dec_inst !== 32'h0050_0093) begin n_fail++; $display("FAIL stream_first_inst got=%h exp=00500093", bus.dec_inst); end
        tick();
        bus.if_valid = 0;
        @(negedge hclk);
        n_checks++; if (bus.issue_valid !== 1'b1 || bus.dec_pc !== 32'h4) begin n_fail++; $display("FAIL stream_second got=%b/%h exp=1/4", bus.issue_valid, bus.dec_pc); end
        tick();
        @(negedge hclk);
        n_checks++; if (bus.dec_valid !== 1'b0 || dbg_state !== IDLE) begin n_fail++; $display("FAIL stream_idle got=%b/%0d exp=0/%0d", bus.dec_valid, dbg_state, IDLE); end
        tick();
    endtask

    task automatic test_load_use();
        int t_rd[5]   = '{1, 0, 2, 3, 1};
        int t_use1[5] = '{1, 1, 1, 1, 0};
        int t_lu[5]   = '{1, 0, 1, 0, 0};
        for (int i = 0; i < 5; i++) begin
            drive_quiet();
            bus.ex_ready = 1;
            drive_push(32'h0020_81B3, 32'h100 + 32'(i * 4));
            tick();
            bus.if_valid = 0;
            bus.dec_rs1 = 5'd1; bus.dec_rs2 = 5'd2;
            bus.dec_uses_rs1 = 1'(t_use1[i]); bus.dec_uses_rs2 = 1;
            bus.ex_load_en = 1; bus.ex_rd = 5'(t_rd[i]);
            @(negedge hclk);
            n_checks++; if (bus.ifu_dec_stall !== 1'(t_lu[i]) || bus.issue_valid !== 1'(!t_lu[i])) begin n_fail++; $display("FAIL lu_stall[%0d] got=%b/%b exp=%0d", i, bus.ifu_dec_stall, bus.issue_valid, t_lu[i]); end
            n_checks++; if (bus.cycle_cnt !== 4'd0) begin n_fail++; $display("FAIL lu_cnt0[%0d] got=%0d exp=0", i, bus.cycle_cnt); end
            tick();
            bus.ex_load_en = 0;
            @(negedge hclk);
            if (t_lu[i] != 0) begin
                n_checks++; if (bus.issue_valid !== 1'b1 || bus.cycle_cnt !== 4'd1) begin n_fail++; $display("FAIL lu_release[%0d] got=%b/%0d exp=1/1", i, bus.issue_valid, bus.cycle_cnt); end
                tick();
                @(negedge hclk);
            end
            n_checks++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL lu_drained[%0d] got=%b exp=0", i, bus.dec_valid); end
            tick();
        end
    endtask

    task automatic test_back_pressure();
        logic [3:0] exp_cnt;
        drive_quiet();
        for (int k = 0; k < 20; k++) begin
            drive_push(32'h1000 + 32'(k), 32'h200 + 32'(4 * k));
            exp_cnt = (k == 0) ? 4'd0 : ((k - 1 > 15) ? 4'd15 : 4'(k - 1));
            @(negedge hclk);
            n_checks++; if (bus.if_ready !== 1'(k < 2)) begin n_fail++; $display("FAIL bp_if_ready[%0d] got=%b exp=%b", k, bus.if_ready, k < 2); end
            n_checks++; if (bus.cycle_cnt !== exp_cnt) begin n_fail++; $display("FAIL bp_cnt[%0d] got=%0d exp=%0d", k, bus.cycle_cnt, exp_cnt); end
            tick();
        end
        bus.if_valid = 0;
        bus.ex_ready = 1;
        @(negedge hclk);
        n_checks++; if (bus.issue_valid !== 1'b1 || bus.dec_pc !== 32'h200 || bus.cycle_cnt !== 4'd15) begin n_fail++; $display("FAIL bp_rel0 got=%b/%h/%0d exp=1/200/15", bus.issue_valid, bus.dec_pc, bus.cycle_cnt); end
        tick();
        @(negedge hclk);
        n_checks++; if (bus.issue_valid !== 1'b1 || bus.dec_pc !== 32'h204 || bus.cycle_cnt !== 4'd0) begin n_fail++; $display("FAIL bp_rel1 got=%b/%h/%0d exp=1/204/0", bus.issue_valid, bus.dec_pc, bus.cycle_cnt); end
        tick();
        @(negedge hclk);
        n_checks++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got=%b exp=0", bus.dec_valid); end
        tick();
    endtask

    task automatic test_flush();
        drive_quiet();
        drive_push(32'h0000_0033, 32'h300); tick();
        drive_push(32'h0000_0033, 32'h304); tick();
        drive_push(32'h0000_0033, 32'h308);
        bus.ex_ready = 1;
        bus.flush = 1;
        @(negedge hclk);
        n_checks++; if (bus.issue_valid !== 1'b0 || bus.if_ready !== 1'b0) begin n_fail++; $display("FAIL flush_edge got=%b/%b exp=0/0", bus.issue_valid, bus.if_ready); end
        tick();
        bus.flush = 0;
        drive_push(32'h0000_0033, 32'h30C);
        @(negedge hclk);
        n_checks++; if (bus.dec_valid !== 1'b0 || bus.if_ready !== 1'b0) begin n_fail++; $display("FAIL flush_rec got=%b/%b exp=0/0", bus.dec_valid, bus.if_ready); end
        n_checks++; if (dbg_state !== FLUSH) begin n_fail++; $display("FAIL flush_state got=%0d exp=%0d", dbg_state, FLUSH); end
        tick();
        bus.if_valid = 0;
        @(negedge hclk);
        n_checks++; if (bus.if_ready !== 1'b1 || bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL flush_idle got=%b/%b exp=1/0", bus.if_ready, bus.dec_valid); end
        tick();
        @(negedge hclk);
        n_checks++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_issue got=%b exp=0", bus.issue_valid); end
        tick();
    endtask

    task automatic test_wrap();
        logic [31:0] sb_q[$];
        logic [31:0] exp_pc;
        drive_quiet();
        bus.ex_ready = 1;
        for (int c = 0; c < 12; c++) begin
            if (c < 10) begin
                drive_push(32'h2000 + 32'(c), 32'h400 + 32'(4 * c));
                sb_q.push_back(32'h400 + 32'(4 * c));
            end else begin
                bus.if_valid = 0;
            end
            @(negedge hclk);
            n_checks++; if (bus.issue_valid !== 1'((c >= 1) && (c <= 10))) begin n_fail++; $display("FAIL wrap_issue[%0d] got=%b", c, bus.issue_valid); end
            n_checks++; if (bus.if_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_if_ready[%0d] got=%b exp=1", c, bus.if_ready); end
            if (c >= 1 && c <= 10) begin
                exp_pc = sb_q.pop_front();
                n_checks++; if (bus.dec_pc !== exp_pc) begin n_fail++; $display("FAIL wrap_order[%0d] got=%h exp=%h", c, bus.dec_pc, exp_pc); end
            end
            tick();
        end
        n_checks++; if (sb_q.size() != 0 || bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_final left=%0d valid=%b", sb_q.size(), bus.dec_valid); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            hrst = ($urandom_range(0, 59) == 0);
            bus.if_valid = 1'($urandom_range(0, 1));
            bus.if_inst = $urandom; bus.if_pc = $urandom;
            bus.ex_ready = ($urandom_range(0, 9) < 7);
            bus.ex_load_en = 1'($urandom_range(0, 1));
            bus.ex_rd = 5'($urandom_range(0, 3));
            bus.dec_rs1 = 5'($urandom_range(0, 3));
            bus.dec_rs2 = 5'($urandom_range(0, 3));
            bus.dec_uses_rs1 = 1'($urandom_range(0, 1));
            bus.dec_uses_rs2 = 1'($urandom_range(0, 1));
            bus.flush = ($urandom_range(0, 19) == 0);
            @(negedge hclk);
            model_eval();
            n_checks++; if (bus.dec_valid !== e_dec_valid || bus.dec_inst !== e_inst || bus.dec_pc !== e_pc) begin n_fail++; $display("FAIL rnd_head[%0d] got=%b/%h/%h exp=%b/%h/%h", c, bus.dec_valid, bus.dec_inst, bus.dec_pc, e_dec_valid, e_inst, e_pc); end
            n_checks++; if (bus.issue_valid !== e_issue || bus.ifu_dec_stall !== e_stall) begin n_fail++; $display("FAIL rnd_issue[%0d] got=%b/%b exp=%b/%b", c, bus.issue_valid, bus.ifu_dec_stall, e_issue, e_stall); end
            n_checks++; if (bus.if_ready !== e_if_ready) begin n_fail++; $display("FAIL rnd_if_ready[%0d] got=%b exp=%b", c, bus.if_ready, e_if_ready); end
            n_checks++; if (bus.cycle_cnt !== e_cnt) begin n_fail++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", c, bus.cycle_cnt, e_cnt); end
            tick();
        end
        hrst = 0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_flush_rec = 0;
        m_cnt = 0;
        hrst = 1;
        drive_quiet();
        test_reset();
        test_streaming();
        test_load_use();
        test_back_pressure();
        test_flush();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dec_issue_ctrl.md
# dec_issue_ctrl

Fetch-to-decode issue controller for the RV32I core. It buffers instructions arriving from the IFU in a small FIFO and presents one instruction per cycle to `dec_swc`. It drives the decoder's `ifu_dec_stall` and `cycle_cnt` inputs, detects load-use hazards from decoder outputs, and releases instructions to EX under an EX-side ready handshake. It sits between the IFU and `dec_swc`, and also takes redirect/flush from the branch unit.

## Interface
- `DEPTH`, 2, FIFO entries; power of two, ≥2
- `NOP`, 32'h0000_0013, instruction presented when no valid head (`addi x0,x0,0`)
- `hclk  in  1  clock`
- `hrst  in  1  synchronous, active-high reset`
- `if_valid  in  1  IFU offers instruction`
- `if_inst  in  32  instruction word`
- `if_pc  in  32  instruction PC`
- `if_ready  out  1  controller accepts; transfer when if_valid && if_ready at hclk rise`
- `dec_inst  out  32  to decoder inst_in`
- `dec_pc  out  32  PC of dec_inst`
- `dec_valid  out  1  dec_inst is a real instruction`
- `ifu_dec_stall  out  1  to decoder; head held this cycle`
- `cycle_cnt  out  4  to decoder; cycles current head has been held`
- `dec_rs1  in  5  from decoder`
- `dec_rs2  in  5  from decoder`
- `dec_uses_rs1  in  1  decoded instruction reads rs1`
- `dec_uses_rs2  in  1  decoded instruction reads rs2`
- `ex_load_en  in  1  instruction in EX is a load`
- `ex_rd  in  5  EX destination register`
- `ex_ready  in  1  EX accepts an instruction this cycle`
- `flush  in  1  redirect; discard all buffered instructions`
- `issue_valid  out  1  head handed to EX this cycle (pop)`

## Operation
- **FSM states:** IDLE (FIFO empty), RUN (head valid), HOLD (head valid, blocked), FLUSH (one-cycle redirect recovery).
- **Head:**
  - `dec_valid` = FIFO not empty and state ≠ FLUSH.
  - `dec_inst`/`dec_pc` = head entry when `dec_valid`; otherwise `NOP`/0.
- **Load-use:** `lu = dec_valid && ex_load_en && ex_rd!=0 && ((dec_uses_rs1 && dec_rs1==ex_rd) || (dec_uses_rs2 && dec_rs2==ex_rd))`.
- **Issue and stall:**
  - `issue_valid = dec_valid && ex_ready && !lu && !flush`.
  - `ifu_dec_stall = dec_valid && !issue_valid`.
- **Transitions:**
  - IDLE→RUN on push.
  - RUN→HOLD when `ifu_dec_stall`.
  - HOLD→RUN on issue with FIFO still non-empty after pop.
  - RUN/HOLD→IDLE on issue that empties the FIFO with no push.
  - Any state→FLUSH on `flush`.
  - FLUSH→IDLE unconditionally next cycle.
- **FIFO:**
  - Read/write pointers of log2(DEPTH)+1 bits; wrap modulo DEPTH.
  - Full when MSBs differ and low bits are equal.
  - `if_ready = !full && state!=FLUSH && !flush`.
  - Push and pop in the same cycle are allowed at any occupancy except full, where `if_ready`=0 (no bypass).
- **cycle_cnt:**
  - 0 on the first cycle a head is presented.
  - +1 per cycle the head is held.
  - Saturates at 15.
  - Clears to 0 on issue, flush, or `dec_valid`=0.
- **Flush:**
  - Same edge: both pointers to 0, incoming push dropped, `issue_valid` forced 0.
  - Takes priority over all simultaneous events.

## Timing
- **Reset:** while `hrst` is sampled high:
  - state=IDLE, pointers=0, `cycle_cnt`=0.
  - Outputs the cycle after: `dec_valid`=0, `dec_inst`=`NOP`, `dec_pc`=0, `ifu_dec_stall`=0, `issue_valid`=0, `if_ready`=1.
- Reset mid-operation discards all entries; there is no partial state.
- **Latency:** push at edge N → head visible from cycle N+1 when the FIFO was empty. Otherwise the entry appears after the preceding entries pop.
- **Throughput:** one issue per cycle sustained with `if_valid`=`ex_ready`=1.
- **Handshake outputs:** `issue_valid`, `ifu_dec_stall` and `if_ready` are combinational from registered state and same-cycle inputs.
- **Load-use bubble:** exactly one bubble when `ex_load_en` drops the following cycle.
- **Flush recovery:** flush asserted at edge N → FLUSH during N+1 (`if_ready`=0) → IDLE and `if_ready`=1 at N+2.

## Structure
- Shared package `core_pkg`:
  - `NOP` constant.
  - FSM state enum `issue_state_t` (2 bits).
  - `XLEN`=32, `REG_AW`=5.
- One sub-module, `dec_issue_fifo`: parameterised on DEPTH and width (64 = inst+pc). It provides push, pop and clear ports plus full/empty flags.
- The FSM, hazard logic and counter stay in the top level.

## Test plan
1. **Reset:** hold `hrst` 3 cycles with `if_valid`=1 → no push. After release: `dec_inst`=32'h13, `dec_valid`=0, `if_ready`=1.
2. **Streaming:** push 0x00500093@pc 0x0, then 0x00A00113@pc 0x4 on consecutive cycles with `ex_ready`=1 → `issue_valid` high on cycles 2 and 3 with matching `dec_pc`, then IDLE.
3. **Load-use:**
   - Head `add x3,x1,x2` (rs1=1, both used) with `ex_load_en`=1, `ex_rd`=1 for one cycle → `ifu_dec_stall`=1, `cycle_cnt`=0; the next cycle issues with `cycle_cnt`=1.
   - Same stimulus with `ex_rd`=0 → no stall.
4. **Back-pressure:** `ex_ready`=0 for 20 cycles with `if_valid`=1 → FIFO fills after 2 pushes, `if_ready`=0, `cycle_cnt` saturates at 15. Releasing `ex_ready` issues both entries in order.
5. **Flush:** with FIFO full and `if_valid`=1, pulse `flush` → next cycle `dec_valid`=0 and `if_ready`=0; the following cycle `if_ready`=1; the flushed PCs never issue.
6. **Wrap-around:** 10 push/pop pairs with DEPTH=2 → issue order equals push order, and full/empty flags stay correct across pointer wrap.
